// File: rtl/counter_cmd_ctrl.sv
// counter_cmd_ctrl: turns debounced button levels into per-channel enable/mode
// state, a channel-select index, and short/long-press clear pulses.
module counter_cmd_ctrl #(
  parameter int NUM_CH      = 4,
  parameter int SEL_W       = 2,
  parameter int LONG_CYCLES = 100_000_000,
  parameter bit MODE_LOCK   = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              btn_enable,
  input  logic              btn_clear,
  input  logic              btn_mode,
  input  logic              btn_sel,
  output logic [NUM_CH-1:0] enable,
  output logic [NUM_CH-1:0] mode,
  output logic [NUM_CH-1:0] clear,
  output logic [SEL_W-1:0]  sel,
  output logic              long_clr
);

  localparam int                CNT_W    = $clog2(LONG_CYCLES + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [SEL_W-1:0]  SEL_LAST = SEL_W'(NUM_CH - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HOLD,
    ST_LONG
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   hold_cnt_q, hold_cnt_d;
  logic               btn_en_q, btn_clr_q, btn_md_q, btn_sel_q;
  logic [NUM_CH-1:0]  enable_q, enable_d;
  logic [NUM_CH-1:0]  mode_q, mode_d;
  logic [NUM_CH-1:0]  clear_q, clear_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic               long_clr_q, long_clr_d;

  logic en_press, md_press, sel_press, clr_press;

  assign en_press  = btn_enable & ~btn_en_q;
  assign md_press  = btn_mode   & ~btn_md_q;
  assign sel_press = btn_sel    & ~btn_sel_q;
  assign clr_press = btn_clear  & ~btn_clr_q;

  // Next-state for channel state, select index and the clear-press FSM.
  // Every action indexes with sel_q so a same-cycle select press does not
  // redirect enable/mode/clear to the new channel.
  always_comb begin
    enable_d   = enable_q;
    mode_d     = mode_q;
    sel_d      = sel_q;
    clear_d    = '0;
    long_clr_d = 1'b0;
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;

    if (en_press) begin
      enable_d[sel_q] = ~enable_q[sel_q];
    end
    if (md_press && !(MODE_LOCK && enable_q[sel_q])) begin
      mode_d[sel_q] = ~mode_q[sel_q];
    end
    if (sel_press) begin
      sel_d = (sel_q == SEL_LAST) ? '0 : sel_q + SEL_W'(1);
    end

    case (state_q)
      ST_IDLE: begin
        if (clr_press) begin
          state_d    = ST_HOLD;
          hold_cnt_d = CNT_ONE;
        end
      end
      ST_HOLD: begin
        if (btn_clear) begin
          if (hold_cnt_q != '1) begin
            hold_cnt_d = hold_cnt_q + CNT_ONE;
          end
          // Fires on the edge where the count reaches LONG_CYCLES.
          if (hold_cnt_q == CNT_LAST) begin
            clear_d    = '1;
            long_clr_d = 1'b1;
            state_d    = ST_LONG;
          end
        end else begin
          clear_d[sel_q] = 1'b1;
          state_d        = ST_IDLE;
          hold_cnt_d     = '0;
        end
      end
      ST_LONG: begin
        if (!btn_clear) begin
          state_d    = ST_IDLE;
          hold_cnt_d = '0;
        end else if (hold_cnt_q != '1) begin
          hold_cnt_d = hold_cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d    = ST_IDLE;
        hold_cnt_d = '0;
      end
    endcase
  end

  // State registers; button history resets high so held buttons are ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      hold_cnt_q <= '0;
      btn_en_q   <= 1'b1;
      btn_clr_q  <= 1'b1;
      btn_md_q   <= 1'b1;
      btn_sel_q  <= 1'b1;
      enable_q   <= '0;
      mode_q     <= '0;
      clear_q    <= '0;
      sel_q      <= '0;
      long_clr_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      btn_en_q   <= btn_enable;
      btn_clr_q  <= btn_clear;
      btn_md_q   <= btn_mode;
      btn_sel_q  <= btn_sel;
      enable_q   <= enable_d;
      mode_q     <= mode_d;
      clear_q    <= clear_d;
      sel_q      <= sel_d;
      long_clr_q <= long_clr_d;
    end
  end

  assign enable   = enable_q;
  assign mode     = mode_q;
  assign clear    = clear_q;
  assign sel      = sel_q;
  assign long_clr = long_clr_q;

endmodule

// File: tb/tb_counter_cmd_ctrl.sv
// Directed, table-driven bench for counter_cmd_ctrl (4 channels, long press = 8).
module tb_counter_cmd_ctrl;

  localparam int NUM_CH      = 4;
  localparam int SEL_W       = 2;
  localparam int LONG_CYCLES = 8;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              btn_enable = 1'b0;
  logic              btn_clear = 1'b0;
  logic              btn_mode = 1'b0;
  logic              btn_sel = 1'b0;
  logic [NUM_CH-1:0] enable, mode, clear;
  logic [SEL_W-1:0]  sel;
  logic              long_clr;

  always #5 clk = ~clk;

  counter_cmd_ctrl #(
    .NUM_CH      (NUM_CH),
    .SEL_W       (SEL_W),
    .LONG_CYCLES (LONG_CYCLES),
    .MODE_LOCK   (1'b1)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .btn_enable (btn_enable),
    .btn_clear  (btn_clear),
    .btn_mode   (btn_mode),
    .btn_sel    (btn_sel),
    .enable     (enable),
    .mode       (mode),
    .clear      (clear),
    .sel        (sel),
    .long_clr   (long_clr)
  );

  // Buttons packed as {enable, clear, mode, sel}.
  typedef struct {
    logic [3:0] btn;
    logic [3:0] e_en;
    logic [3:0] e_md;
    logic [3:0] e_clr;
    logic [1:0] e_sel;
    logic       e_long;
  } vec_t;

  vec_t vecs[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  function automatic vec_t mk(input logic [3:0] btn, input logic [3:0] en,
                              input logic [3:0] md, input logic [3:0] clr,
                              input logic [1:0] s, input logic l);
    vec_t v;
    v.btn = btn; v.e_en = en; v.e_md = md; v.e_clr = clr; v.e_sel = s; v.e_long = l;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [3:0] en, input logic [3:0] md,
                           input logic [3:0] clr, input logic [1:0] s, input logic l);
    check({tag, ".enable"},   32'(enable),   32'(en));
    check({tag, ".mode"},     32'(mode),     32'(md));
    check({tag, ".clear"},    32'(clear),    32'(clr));
    check({tag, ".sel"},      32'(sel),      32'(s));
    check({tag, ".long_clr"}, 32'(long_clr), 32'(l));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset with btn_enable held throughout and afterwards.
    rst_n = 1'b0;
    btn_enable = 1'b1;
    repeat (3) step();
    check_all("reset", 4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check($sformatf("held_after_reset[%0d].enable", i), 32'(enable), 32'h0);
    end
    btn_enable = 1'b0;
    step();
    check("held_release.enable", 32'(enable), 32'h0);
    btn_enable = 1'b1;
    step();
    check_all("repress", 4'b0001, 4'b0000, 4'b0000, 2'd0, 1'b0);
    btn_enable = 1'b0;
    step();
    check_all("repress_low", 4'b0001, 4'b0000, 4'b0000, 2'd0, 1'b0);

    // Mode lock (sel=0, enable[0]=1).
    vecs.push_back(mk(4'b0010, 4'b0001, 4'b0000, 4'b0000, 2'd0, 1'b0));
    vecs.push_back(mk(4'b0000, 4'b0001, 4'b0000, 4'b0000, 2'd0, 1'b0));
    vecs.push_back(mk(4'b1000, 4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0));
    vecs.push_back(mk(4'b0000, 4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0));
    vecs.push_back(mk(4'b0010, 4'b0000, 4'b0001, 4'b0000, 2'd0, 1'b0));
    vecs.push_back(mk(4'b0000, 4'b0000, 4'b0001, 4'b0000, 2'd0, 1'b0));
    // Select up to 3, enable channel 3, wrap to 0.
    for (int s = 1; s <= 3; s++) begin
      vecs.push_back(mk(4'b0001, 4'b0000, 4'b0001, 4'b0000, 2'(s), 1'b0));
      vecs.push_back(mk(4'b0000, 4'b0000, 4'b0001, 4'b0000, 2'(s), 1'b0));
    end
    vecs.push_back(mk(4'b1000, 4'b1000, 4'b0001, 4'b0000, 2'd3, 1'b0));
    vecs.push_back(mk(4'b0000, 4'b1000, 4'b0001, 4'b0000, 2'd3, 1'b0));
    vecs.push_back(mk(4'b0001, 4'b1000, 4'b0001, 4'b0000, 2'd0, 1'b0));
    vecs.push_back(mk(4'b0000, 4'b1000, 4'b0001, 4'b0000, 2'd0, 1'b0));
    // Simultaneous select + enable at sel=1: toggles channel 1, sel -> 2.
    vecs.push_back(mk(4'b0001, 4'b1000, 4'b0001, 4'b0000, 2'd1, 1'b0));
    vecs.push_back(mk(4'b0000, 4'b1000, 4'b0001, 4'b0000, 2'd1, 1'b0));
    vecs.push_back(mk(4'b1001, 4'b1010, 4'b0001, 4'b0000, 2'd2, 1'b0));
    vecs.push_back(mk(4'b0000, 4'b1010, 4'b0001, 4'b0000, 2'd2, 1'b0));
    // Short clear: 3-cycle hold at sel=2.
    for (int i = 0; i < 3; i++)
      vecs.push_back(mk(4'b0100, 4'b1010, 4'b0001, 4'b0000, 2'd2, 1'b0));
    vecs.push_back(mk(4'b0000, 4'b1010, 4'b0001, 4'b0100, 2'd2, 1'b0));
    vecs.push_back(mk(4'b0000, 4'b1010, 4'b0001, 4'b0000, 2'd2, 1'b0));
    // Boundary: LONG_CYCLES-1 high samples is still a short press.
    for (int i = 0; i < LONG_CYCLES - 1; i++)
      vecs.push_back(mk(4'b0100, 4'b1010, 4'b0001, 4'b0000, 2'd2, 1'b0));
    vecs.push_back(mk(4'b0000, 4'b1010, 4'b0001, 4'b0100, 2'd2, 1'b0));
    vecs.push_back(mk(4'b0000, 4'b1010, 4'b0001, 4'b0000, 2'd2, 1'b0));
    // Long clear: 20-cycle hold, pulse on the 8th high sample only.
    for (int i = 0; i < 20; i++)
      vecs.push_back(mk(4'b0100, 4'b1010, 4'b0001, (i == 7) ? 4'b1111 : 4'b0000,
                        2'd2, (i == 7)));
    vecs.push_back(mk(4'b0000, 4'b1010, 4'b0001, 4'b0000, 2'd2, 1'b0));
    vecs.push_back(mk(4'b0000, 4'b1010, 4'b0001, 4'b0000, 2'd2, 1'b0));

    foreach (vecs[i]) begin
      {btn_enable, btn_clear, btn_mode, btn_sel} = vecs[i].btn;
      step();
      check_all($sformatf("vec[%0d]", i), vecs[i].e_en, vecs[i].e_md, vecs[i].e_clr,
                vecs[i].e_sel, vecs[i].e_long);
    end

    // Reset mid-hold: no pulse, and the still-held button must not restart a hold.
    btn_clear = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check($sformatf("midhold[%0d].clear", i), 32'(clear), 32'h0);
    end
    rst_n = 1'b0;
    step();
    check_all("midhold_reset", 4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0);
    rst_n = 1'b1;
    for (int i = 0; i < 2 * LONG_CYCLES; i++) begin
      step();
      check($sformatf("post_reset_hold[%0d].clear", i), 32'(clear), 32'h0);
      check($sformatf("post_reset_hold[%0d].long_clr", i), 32'(long_clr), 32'h0);
    end
    btn_clear = 1'b0;
    step();
    check("post_reset_release.clear", 32'(clear), 32'h0);
    btn_clear = 1'b1;
    step();
    check("press2_a.clear", 32'(clear), 32'h0);
    step();
    check("press2_b.clear", 32'(clear), 32'h0);
    btn_clear = 1'b0;
    step();
    check_all("press2_release", 4'b0000, 4'b0000, 4'b0001, 2'd0, 1'b0);
    step();
    check("press2_after.clear", 32'(clear), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/counter_cmd_ctrl.md
# counter_cmd_ctrl

Multi-channel command controller for the counter/FND datapath. Converts debounced push-button levels into per-channel control state (run enable, count direction) and clear pulses for `NUM_CH` independent counters, with a channel-select button and short/long-press discrimination on clear. It sits between the button debouncers and the counter bank, replacing the single-channel controller.

## Interface

- `NUM_CH`, 4: number of counter channels, legal range 2..16.
- `SEL_W`, 2: width of the channel-select index, equal to ceil(log2(`NUM_CH`)) and at least 1.
- `LONG_CYCLES`, 100_000_000: consecutive high cycles of `btn_clear` that count as a long press, minimum 2.
- `MODE_LOCK`, 1: when 1, a mode toggle is ignored while the selected channel is enabled.
- `clk` input 1: system clock, rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `btn_enable` input 1: debounced level, synchronous to `clk`.
- `btn_clear` input 1: debounced level.
- `btn_mode` input 1: debounced level.
- `btn_sel` input 1: debounced level.
- `enable` output `NUM_CH`: per-channel run enable.
- `mode` output `NUM_CH`: per-channel direction, 0 up, 1 down.
- `clear` output `NUM_CH`: per-channel clear, one-cycle pulses.
- `sel` output `SEL_W`: currently selected channel.
- `long_clr` output 1: one-cycle flag, high together with an all-channel clear.

## Operation

- Each button has a registered previous-value flop. A press is `btn & ~btn_q`; a release is `~btn & btn_q`.
- `btn_sel` press: `sel` increments. `NUM_CH-1` wraps to 0. Values >= `NUM_CH` are never produced.
- `btn_enable` press: `enable[sel]` toggles.
- `btn_mode` press: `mode[sel]` toggles. If `MODE_LOCK`=1 and `enable[sel]`=1, the press is dropped and not queued.
- Clear FSM, states IDLE, HOLD, LONG:
  - IDLE: on a `btn_clear` press, go to HOLD and set `hold_cnt` = 1.
  - HOLD: while the button is high, `hold_cnt` increments. When `hold_cnt` reaches `LONG_CYCLES`, pulse `clear` all-ones and `long_clr`, then go to LONG. On a release before that, pulse `clear[sel]` only and go to IDLE.
  - LONG: stay until release, with no further pulses. On release, go to IDLE.
  - `hold_cnt` is wide enough for `LONG_CYCLES` and saturates.
- Clearing never changes `enable`, `mode` or `sel`.
- Simultaneous events in one cycle: all actions use the `sel` value from before this cycle's `btn_sel` press. Enable, mode and clear actions are independent and all take effect.
- Reset: `enable`=0, `mode`=0, `clear`=0, `long_clr`=0, `sel`=0, FSM in IDLE, `hold_cnt`=0. All `btn_q` flops reset to 1, so a button held through reset is ignored until it is released and pressed again.
- Reset mid-hold aborts the hold with no clear pulse.

## Timing

- Latency: a press or release sampled at rising edge N updates the outputs at edge N. The new value is visible for the cycle after N.
- `clear` and `long_clr` are high for exactly one cycle per event.
- Long clear: with the button first sampled high at edge N, the pulse is high in the cycle after edge N+`LONG_CYCLES`-1.
- Short clear: the pulse comes in the cycle after the edge that samples the release.
- Back-to-back presses need at least one low sample between them. A level held high is one press.
- All outputs are registered. There are no combinational paths from the buttons to the outputs.

## Test plan

Bench configuration for all scenarios: `NUM_CH`=4, `LONG_CYCLES`=8, `MODE_LOCK`=1.

- **Reset with button held:** `rst_n` low with `btn_enable` high, then release reset and hold the button 5 more cycles -> `enable`=0000 throughout. A later release and re-press -> `enable`=0001.
- **Select wrap and per-channel enable:** press `btn_sel` 3 times -> `sel`=3. Press `btn_enable` -> `enable`=1000. Press `btn_sel` once more -> `sel`=0.
- **Mode lock:** `sel`=0, `enable[0]`=1, press `btn_mode` -> `mode`=0000 unchanged. Disable channel 0, press `btn_mode` -> `mode`=0001.
- **Short vs long clear:**
  - `sel`=2, hold `btn_clear` 3 cycles -> single `clear`=0100 pulse after release, `long_clr`=0.
  - Hold 20 cycles -> single `clear`=1111 and `long_clr`=1 on cycle 8, no pulse on release.
- **Simultaneous press:** `sel`=1, press `btn_sel` and `btn_enable` in the same cycle -> `enable[1]` toggles and `sel` becomes 2.
- **Reset mid-hold:** hold `btn_clear` 5 cycles, pulse `rst_n` low, keep the button high -> no `clear` pulse, FSM in IDLE. After release, a 2-cycle press gives a `clear`=0001 pulse.
